// File: rtl/alu_seq_ctrl_if.sv
// Request / ALU / result bundle between alu_seq_ctrl and its neighbours.
// slave is the controller's view; master is the surrounding logic's view.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [RES_W-1:0]  alu_out;
  logic              alu_cout;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_cout;
  logic              res_illegal;
  logic [15:0]       op_count;

  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_out, alu_cout, res_ready,
    output in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_cout,
           res_illegal, op_count
  );

  modport master (
    output in_valid, in_a, in_b, in_op, alu_out, alu_cout, res_ready,
    input  in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_cout,
           res_illegal, op_count
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer around an external combinational ALU: latch operands, capture the
// result one cycle later, hold it until downstream takes it, count deliveries.
module alu_seq_ctrl #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  logic [1:0]        state_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [2:0]        alu_sel_q;
  logic              res_valid_q;
  logic [RES_W-1:0]  res_data_q;
  logic              res_cout_q;
  logic              res_illegal_q;
  logic [15:0]       op_count_q;

  // Opcodes 6/7 are reserved; carry is only defined for ADD (0) and SUB (1).
  logic sel_illegal;
  logic sel_arith;
  assign sel_illegal = alu_sel_q[2] & alu_sel_q[1];
  assign sel_arith   = (alu_sel_q[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    // NOTE: every register here, result and counter included, is cleared by
    // reset so an aborted operation leaves nothing visible downstream.
    if (!rst_n) begin
      state_q       <= IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_cout_q    <= 1'b0;
      res_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, regardless of statement order.
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            alu_a_q   <= bus.in_a;
            alu_b_q   <= bus.in_b;
            alu_sel_q <= bus.in_op;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (sel_illegal) begin
            res_data_q    <= '0;
            res_cout_q    <= 1'b0;
            res_illegal_q <= 1'b1;
          end else begin
            res_data_q    <= bus.alu_out;
            res_cout_q    <= sel_arith & bus.alu_cout;
            res_illegal_q <= 1'b0;
          end
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (op_count_q != 16'hFFFF) begin
              op_count_q <= op_count_q + 16'd1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Pure state decode: upstream can never see in_ready react to its own inputs.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_cout    = res_cout_q;
  assign bus.res_illegal = res_illegal_q;
  assign bus.op_count    = op_count_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and randomized checks of alu_seq_ctrl against an arithmetic model,
// with a stand-in combinational ALU attached to the alu_* side.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.DATA_W(4), .RES_W(8)) bif ();

  alu_seq_ctrl #(.DATA_W(4), .RES_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // Stand-in ALU: 4-bit ADD/SUB sign-extended, logic ops zero-extended, full
  // 8-bit product. Junk carry / result on ops where the controller must mask.
  logic [4:0] sum5;
  always_comb begin
    sum5         = '0;
    bif.alu_out  = 8'h00;
    bif.alu_cout = 1'b0;
    case (bif.alu_sel)
      3'd0: begin
        sum5         = {1'b0, bif.alu_a} + {1'b0, bif.alu_b};
        bif.alu_out  = {{4{sum5[3]}}, sum5[3:0]};
        bif.alu_cout = sum5[4];
      end
      3'd1: begin
        sum5         = {1'b0, bif.alu_a} + {1'b0, ~bif.alu_b} + 5'd1;
        bif.alu_out  = {{4{sum5[3]}}, sum5[3:0]};
        bif.alu_cout = sum5[4];
      end
      3'd2: begin bif.alu_out = {4'h0, bif.alu_a & bif.alu_b}; bif.alu_cout = 1'b1; end
      3'd3: begin bif.alu_out = {4'h0, bif.alu_a | bif.alu_b}; bif.alu_cout = 1'b1; end
      3'd4: begin bif.alu_out = {4'h0, bif.alu_a ^ bif.alu_b}; bif.alu_cout = 1'b1; end
      3'd5: begin bif.alu_out = {4'h0, bif.alu_a} * {4'h0, bif.alu_b}; bif.alu_cout = 1'b1; end
      default: begin bif.alu_out = 8'hA5; bif.alu_cout = 1'b1; end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sext4(input int v);
    int m;
    m = ((v % 16) + 16) % 16;
    return (m >= 8) ? 8'(m + 240) : 8'(m);
  endfunction

  // Returns {illegal, cout, data} straight from the opcode table.
  function automatic logic [9:0] ref_op(input int a, input int b, input int op);
    case (op)
      0:       return {1'b0, 1'(a + b > 15), sext4(a + b)};
      1:       return {1'b0, 1'(a >= b),     sext4(a - b)};
      2:       return {2'b00, 8'(a & b)};
      3:       return {2'b00, 8'(a | b)};
      4:       return {2'b00, 8'(a ^ b)};
      5:       return {2'b00, 8'(a * b)};
      default: return {1'b1, 1'b0, 8'h00};
    endcase
  endfunction

  // Entered just after a negedge with the DUT idle; leaves it idle again.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input int hold, input bit noise);
    logic [9:0] exp;
    exp = ref_op(int'(a), int'(b), int'(op));
    check("idle_ready", 16'(bif.in_ready), 16'd1);
    bif.in_valid  = 1'b1;
    bif.in_a      = a;
    bif.in_b      = b;
    bif.in_op     = op;
    bif.res_ready = (hold == 0);
    @(negedge clk);
    bif.in_valid = noise;
    if (noise) begin
      bif.in_a  = 4'($urandom);
      bif.in_b  = 4'($urandom);
      bif.in_op = 3'($urandom);
    end
    check("exec_alu_a", 16'(bif.alu_a), 16'(a));
    check("exec_alu_b", 16'(bif.alu_b), 16'(b));
    check("exec_alu_sel", 16'(bif.alu_sel), 16'(op));
    check("exec_ready", 16'(bif.in_ready), 16'd0);
    check("exec_valid", 16'(bif.res_valid), 16'd0);
    @(negedge clk);
    check("cap_valid", 16'(bif.res_valid), 16'd1);
    check("cap_data", 16'(bif.res_data), 16'(exp[7:0]));
    check("cap_cout", 16'(bif.res_cout), 16'(exp[8]));
    check("cap_illegal", 16'(bif.res_illegal), 16'(exp[9]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", 16'(bif.res_data), 16'(exp[7:0]));
      check("hold_cout", 16'(bif.res_cout), 16'(exp[8]));
      check("hold_illegal", 16'(bif.res_illegal), 16'(exp[9]));
      check("hold_valid", 16'(bif.res_valid), 16'd1);
      check("hold_ready", 16'(bif.in_ready), 16'd0);
      check("hold_alu_a", 16'(bif.alu_a), 16'(a));
      check("hold_alu_sel", 16'(bif.alu_sel), 16'(op));
    end
    bif.res_ready = 1'b1;
    @(negedge clk);
    bif.res_ready = 1'b0;
    bif.in_valid  = 1'b0;
    exp_count     = (exp_count < 65535) ? exp_count + 1 : 65535;
    check("dlv_valid", 16'(bif.res_valid), 16'd0);
    check("dlv_ready", 16'(bif.in_ready), 16'd1);
    check("dlv_count", bif.op_count, 16'(exp_count));
    check("dlv_alu_a", 16'(bif.alu_a), 16'(a));
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_a      = 4'h5;
    bif.in_b      = 4'h6;
    bif.in_op     = 3'd2;
    bif.res_ready = 1'b1;

    // Reset with a pending request and res_ready high: reset must win.
    repeat (3) @(negedge clk);
    check("rst_valid", 16'(bif.res_valid), 16'd0);
    check("rst_data", 16'(bif.res_data), 16'd0);
    check("rst_cout", 16'(bif.res_cout), 16'd0);
    check("rst_illegal", 16'(bif.res_illegal), 16'd0);
    check("rst_alu_a", 16'(bif.alu_a), 16'd0);
    check("rst_alu_b", 16'(bif.alu_b), 16'd0);
    check("rst_alu_sel", 16'(bif.alu_sel), 16'd0);
    check("rst_count", bif.op_count, 16'd0);
    check("rst_ready", 16'(bif.in_ready), 16'd1);
    bif.in_valid  = 1'b0;
    bif.res_ready = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 16'(bif.in_ready), 16'd1);

    // Reset while in DONE: result dropped, counter stays at 0.
    bif.in_valid = 1'b1; bif.in_a = 4'h1; bif.in_b = 4'h2; bif.in_op = 3'd0;
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
    check("done_abort_pre", 16'(bif.res_valid), 16'd1);
    bif.res_ready = 1'b1;
    apply_reset(1);
    bif.res_ready = 1'b0;
    check("done_abort_valid", 16'(bif.res_valid), 16'd0);
    check("done_abort_count", bif.op_count, 16'd0);
    check("done_abort_ready", 16'(bif.in_ready), 16'd1);
    @(negedge clk);
    check("done_abort_ready2", 16'(bif.in_ready), 16'd1);

    // Reset while in EXEC: nothing is captured.
    bif.in_valid = 1'b1; bif.in_a = 4'h3; bif.in_b = 4'h4; bif.in_op = 3'd5;
    @(negedge clk);
    bif.in_valid = 1'b0;
    apply_reset(1);
    check("exec_abort_valid", 16'(bif.res_valid), 16'd0);
    check("exec_abort_data", 16'(bif.res_data), 16'd0);
    check("exec_abort_alu_sel", 16'(bif.alu_sel), 16'd0);
    check("exec_abort_ready", 16'(bif.in_ready), 16'd1);

    // Directed operations.
    do_op(4'h7, 4'h9, 3'd0, 0, 1'b0);   // ADD wraps to 0 with carry
    do_op(4'hF, 4'hF, 3'd5, 5, 1'b0);   // MUL held for five cycles
    do_op(4'h3, 4'h3, 3'd6, 1, 1'b0);   // reserved opcode
    do_op(4'hC, 4'hA, 3'd2, 0, 1'b0);   // AND clears the illegal flag
    do_op(4'h2, 4'h5, 3'd1, 2, 1'b1);   // SUB with ignored in_valid pulses
    do_op(4'h6, 4'h3, 3'd4, 0, 1'b1);   // XOR, junk ALU carry must be masked
    do_op(4'h9, 4'h1, 3'd7, 0, 1'b0);   // other reserved opcode

    // Unreachable state encoding falls back to IDLE.
    force u_dut.state_q = 2'b11;
    #1;
    check("bad_state_ready", 16'(bif.in_ready), 16'd0);
    release u_dut.state_q;
    @(negedge clk);
    check("bad_state_recover", 16'(bif.in_ready), 16'd1);

    // Randomized operations with random back-pressure and noise.
    for (int k = 0; k < 24; k++) begin
      do_op(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Counter saturation.
    force u_dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release u_dut.op_count_q;
    exp_count = 65534;
    check("preset_count", bif.op_count, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      do_op(4'($urandom), 4'($urandom), 3'($urandom_range(0, 5)), 0, 1'b0);
    end
    check("sat_count", bif.op_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
